muldiv_ctrl: RTL

Sequencer for the shared iterative multiply/divide unit in the Execute stage of the pipelined RISC-V core (RV32M ops).
- Latches operands when an M-extension instruction reaches E.
- Issues a start pulse to the unit and holds the pipeline (F/D/E stall, bubble into M) until the result returns.
- Presents the result to the E-stage result mux for exactly one cycle.
- Its stall/bubble outputs are OR-ed with the hazard unit's stallF/stallD/flushE paths at the top level.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_fastpath.sv | 27 ++
 rtl/muldiv_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and defaults for the RV32M sequencer
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam int MAX_CYCLES_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_fastpath.sv
// rtl/muldiv_fastpath.sv - trivial-case detect (divide by zero, multiply by zero) with its result
module muldiv_fastpath
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_hit,
  output logic [XLEN-1:0] o_result
);

  always_comb begin
    o_hit    = 1'b0;
    o_result = '0;
    if (op_is_div(i_op)) begin
      if (i_b == '0) begin
        o_hit    = 1'b1;
        o_result = (i_op == OP_DIV || i_op == OP_DIVU) ? '1 : i_a;
      end
    end else if (i_a == '0 || i_b == '0) begin
      o_hit = 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - E-stage sequencer for the iterative mul/div unit
// Optional trivial-case bypass is enabled by defining MULDIV_FASTPATH_EN.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdE,
  input  logic [2:0]      md_opE,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic            unit_done,
  input  logic [XLEN-1:0] unit_result,
  output logic            unit_start,
  output logic [2:0]      unit_op,
  output logic [XLEN-1:0] unit_a,
  output logic [XLEN-1:0] unit_b,
  output logic            stall_md,
  output logic            bubbleM,
  output logic            md_validE,
  output logic [XLEN-1:0] md_resultE,
  output logic            md_timeout
);

  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic            w_fast_hit;
  logic [XLEN-1:0] w_fast_result;
  logic            w_cnt_last;

`ifdef MULDIV_FASTPATH_EN
  muldiv_fastpath #(.XLEN(XLEN)) u_fastpath (
    .i_op     (md_opE),
    .i_a      (srcAE),
    .i_b      (srcBE),
    .o_hit    (w_fast_hit),
    .o_result (w_fast_result)
  );
`else
  assign w_fast_hit    = 1'b0;
  assign w_fast_result = '0;
`endif

  assign w_cnt_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (mdE) w_next = w_fast_hit ? DONE : BUSY;
      BUSY: if (unit_done || w_cnt_last) w_next = DONE;
      // The mdE seen in DONE is still the finishing instruction.
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mdE) begin
            r_op  <= md_opE;
            r_a   <= srcAE;
            r_b   <= srcBE;
            r_cnt <= '0;
            if (w_fast_hit) r_result <= w_fast_result;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          if (unit_done)       r_result <= unit_result;
          else if (w_cnt_last) r_result <= '1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unit_start = 1'b0;
    stall_md   = 1'b0;
    md_validE  = 1'b0;
    md_resultE = '0;
    md_timeout = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          stall_md   = mdE;
          unit_start = mdE && !w_fast_hit;
        end
        BUSY: begin
          stall_md   = 1'b1;
          md_timeout = !unit_done && w_cnt_last;
        end
        DONE: begin
          md_validE  = 1'b1;
          md_resultE = r_result;
        end
        default: ;
      endcase
    end
  end

  assign bubbleM = stall_md;
  assign unit_op = rst ? 3'b000 : r_op;
  assign unit_a  = rst ? '0 : r_a;
  assign unit_b  = rst ? '0 : r_b;

endmodule
